psum_requant: RTL

Requantizes 32-bit signed products and partial sums from the multiplier and accumulator path back to the 8-bit Q1.7 activation format. The conversion applies a rounded arithmetic right shift, then saturates the result. It sits at the output edge of the systolic array, between the PE accumulators and the activation writeback buffer. A 3-stage valid/ready pipeline carries the data, and a sticky saturation counter supports debug.

---
 rtl/npu_quant_pkg.sv | 18 +
 rtl/psum_requant_pipe_slice.sv | 40 ++++
 rtl/psum_requant.sv | 120 ++++++++++++
 3 files changed

// File: rtl/npu_quant_pkg.sv
// Shared quantisation constants and types for the NPU output path.
// Accumulator is Q18.14, activations are Q1.7.
package npu_quant_pkg;

  localparam int ACC_WIDTH  = 32;
  localparam int ACT_WIDTH  = 8;
  localparam int ACC_FRAC   = 14;
  localparam int ACT_FRAC   = 7;
  localparam int FRAC_SHIFT_DEF = ACC_FRAC - ACT_FRAC;
  localparam int SAT_CNT_WIDTH_DEF = 16;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic signed [ACT_WIDTH-1:0] act_t;

  localparam act_t ACT_MAX = 8'sd127;
  localparam act_t ACT_MIN = -8'sd128;

endpackage

// File: rtl/psum_requant_pipe_slice.sv
// Bubble-collapsing valid/ready register slice.
// Ports: in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data
// downstream; clk, rst_n (async, active-high).
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Empty or draining this cycle: free to load.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_ready && in_valid) ? in_data : data_q;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/psum_requant.sv
// Requantise signed accumulator words to saturated Q1.7 activations.
// Ports: in_valid/in_ready/in_data/in_last in; out_valid/out_ready/
// out_data/out_last/out_sat out; sat_clear/sat_count debug counter;
// clk, rst_n (async, active-high).
module psum_requant
  import npu_quant_pkg::*;
#(
  parameter int IN_WIDTH      = ACC_WIDTH,
  parameter int OUT_WIDTH     = ACT_WIDTH,
  parameter int FRAC_SHIFT    = FRAC_SHIFT_DEF,
  parameter int SAT_CNT_WIDTH = SAT_CNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_WIDTH-1:0]      in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_last,
  output logic                     out_sat,
  input  logic                     sat_clear,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
);

  localparam int XW  = IN_WIDTH + 1;
  localparam int S1W = IN_WIDTH + 1;
  localparam int S2W = XW + 1;
  localparam int S3W = OUT_WIDTH + 2;

  localparam logic signed [XW-1:0] RND = XW'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [XW-1:0] HI  = XW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] LO  = -HI - XW'(1);

  logic           s1_valid, s1_ready;
  logic [S1W-1:0] s1_data;
  logic           s2_valid, s2_ready;
  logic [S2W-1:0] s2_data;
  logic [S3W-1:0] s3_data;

  // S1: capture
  pipe_slice #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_last, in_data}),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_data)
  );

  // Extra sign bit keeps +half from wrapping at the max positive input.
  logic signed [XW-1:0] s1_ext, s1_rnd;
  always_comb begin
    s1_ext = {s1_data[IN_WIDTH-1], s1_data[IN_WIDTH-1:0]};
    s1_rnd = (s1_ext + RND) >>> FRAC_SHIFT;
  end

  // S2: round and shift
  pipe_slice #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .in_data   ({s1_data[IN_WIDTH], s1_rnd}),
    .out_valid (s2_valid),
    .out_ready (s2_ready),
    .out_data  (s2_data)
  );

  logic signed [XW-1:0]  s2_val;
  logic                  s2_hi, s2_lo;
  logic [OUT_WIDTH-1:0]  s2_act;
  always_comb begin
    s2_val = s2_data[XW-1:0];
    s2_hi  = s2_val > HI;
    s2_lo  = s2_val < LO;
    s2_act = s2_val[OUT_WIDTH-1:0];
    if (s2_hi) s2_act = HI[OUT_WIDTH-1:0];
    if (s2_lo) s2_act = LO[OUT_WIDTH-1:0];
  end

  // S3: saturate
  pipe_slice #(.W(S3W)) u_s3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s2_valid),
    .in_ready  (s2_ready),
    .in_data   ({s2_data[XW], s2_hi || s2_lo, s2_act}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s3_data)
  );

  assign out_data = s3_data[OUT_WIDTH-1:0];
  assign out_sat  = s3_data[OUT_WIDTH];
  assign out_last = s3_data[OUT_WIDTH+1];

  logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  // Clear wins over a same-cycle saturated handshake.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clear)
      sat_count_d = '0;
    else if (out_valid && out_ready && out_sat && (sat_count_q != '1))
      sat_count_d = sat_count_q + SAT_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) sat_count_q <= '0;
    else       sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;

endmodule
